secded_err_monitor: RTL and testbench
=====================================

// Module: secded_err_monitor
// PURPOSE
//   Downstream of the SECDED decoder: samples per-word decoder flags on valid_i, keeps saturating
//   single/double-error counters, holds a one-entry error log with ack handshake, and runs a
//   health FSM (OK/DEGRADED/FATAL) that raises alarm_o/fatal_o for the system controller.
// PARAMETERS
//   K         4  data width of decoded word
//   M         3  Hamming redundant bits; syndrome width is M+1 (bit 0 = overall parity)
//   CNT_W     8  width of each error counter
//   SB_THRESH 4  corrected-error count at which the FSM enters DEGRADED (1..2**CNT_W-1)
// PORTS
//   clk_i           in   1      clock, all state on rising edge
//   rst_i           in   1      asynchronous, active-high reset
//   valid_i         in   1      decoder outputs below are valid this cycle
//   sb_err_i        in   1      decoder single-bit error flag
//   db_err_i        in   1      decoder double-bit error flag
//   sb_fix_i        in   1      decoder reports single-bit error corrected
//   syndrome_i      in   M+1    decoder syndrome
//   data_i          in   K      decoder corrected data
//   clr_i           in   1      synchronous clear of counters, log, overflow, FSM
//   log_ack_i       in   1      consumer acknowledges current log entry
//   sb_cnt_o        out  CNT_W  corrected-error count (saturating)
//   db_cnt_o        out  CNT_W  uncorrectable-error count (saturating)
//   log_valid_o     out  1      log entry held
//   log_type_o      out  1      0 = corrected, 1 = uncorrectable
//   log_syndrome_o  out  M+1    syndrome of logged error
//   log_data_o      out  K      data of logged error
//   log_ovf_o       out  1      sticky: error arrived while log full
//   alarm_o         out  1      FSM in DEGRADED or FATAL
//   fatal_o         out  1      FSM in FATAL
// BEHAVIOUR
//   - Reset: all outputs 0, counters 0, log empty, FSM = OK. Applies immediately, mid-operation too.
//   - Classification (only when valid_i=1): db_err_i=1 -> UE; else sb_err_i=1 & sb_fix_i=1 -> CE;
//     else sb_err_i=1 & sb_fix_i=0 -> UE; else no error. db_err_i wins if both flags set.
//   - Counters: CE increments sb_cnt_o, UE increments db_cnt_o; hold at 2**CNT_W-1. All outputs
//     registered; effect visible cycle after valid_i sample (latency 1).
//   - Log: on error with log empty (or being acked this cycle) capture type/syndrome/data,
//     log_valid_o=1 next cycle. Holds until log_ack_i while log_valid_o=1; ack with log empty ignored.
//     Error while log full and no ack -> entry kept, log_ovf_o=1 (sticky until clr_i/reset).
//     Same-cycle ack + new error -> new error captured, no overflow.
//   - FSM: OK -> DEGRADED when post-update sb count >= SB_THRESH; OK/DEGRADED -> FATAL on any UE;
//     DEGRADED never returns to OK except via clr_i; FATAL exits only via clr_i/reset.
//     alarm_o/fatal_o follow next state, i.e. same cycle as counter update.
//   - clr_i: counters 0, log empty, log_ovf_o=0, FSM=OK next cycle; clr_i has priority over a
//     simultaneous valid_i (that sample is dropped) and over log_ack_i.
//   - valid_i=0: inputs ignored, no state change besides ack/clr.
// CONFIGURATION
//   SECDED_MON_TS_EN defined: adds free-running 16-bit cycle counter (0 at reset, wraps 0xFFFF->0,
//     not cleared by clr_i) and output port log_ts_o [15:0] holding counter value at capture.
//   Not defined: no timestamp counter, no log_ts_o port; all other behaviour identical.
// TESTING
//   - Reset: rst_i=1 mid-stream with log full, FSM=FATAL -> all outputs 0 same cycle, FSM OK.
//   - 4 CE (sb_err=1,sb_fix=1,syndrome=0x5) with SB_THRESH=4 -> sb_cnt_o=4, alarm_o=1 after 4th,
//     log holds first (type 0, syndrome 0x5), log_ovf_o=1 from second CE.
//   - UE via db_err_i=1 and via sb_err=1,sb_fix=0 -> db_cnt_o=2, fatal_o=1 after first, type 1 logged.
//   - Ack with same-cycle CE -> new entry captured, log_valid_o stays 1, log_ovf_o stays 0.
//   - 300 CE with CNT_W=8 -> sb_cnt_o saturates at 255; clr_i with valid_i UE -> counts 0, FSM OK, fatal_o=0.
//   - SECDED_MON_TS_EN: CE at cycle 10 after reset -> log_ts_o=10; counter wraps after 65536 cycles.

Source files
------------

// File: rtl/secded_err_monitor_if.sv
// Decoder-flag and monitor-status bundle for secded_err_monitor.
// The master drives the decoder outputs plus clr/ack; the slave (the monitor) drives the status outputs.
interface secded_err_monitor_if #(
  parameter int K     = 4,
  parameter int M     = 3,
  parameter int CNT_W = 8
);
  logic             valid_i;
  logic             sb_err_i;
  logic             db_err_i;
  logic             sb_fix_i;
  logic [M:0]       syndrome_i;
  logic [K-1:0]     data_i;
  logic             clr_i;
  logic             log_ack_i;

  logic [CNT_W-1:0] sb_cnt_o;
  logic [CNT_W-1:0] db_cnt_o;
  logic             log_valid_o;
  logic             log_type_o;
  logic [M:0]       log_syndrome_o;
  logic [K-1:0]     log_data_o;
  logic             log_ovf_o;
  logic             alarm_o;
  logic             fatal_o;

  modport master (
    output valid_i, sb_err_i, db_err_i, sb_fix_i, syndrome_i, data_i, clr_i, log_ack_i,
    input  sb_cnt_o, db_cnt_o, log_valid_o, log_type_o, log_syndrome_o, log_data_o,
           log_ovf_o, alarm_o, fatal_o
  );

  modport slave (
    input  valid_i, sb_err_i, db_err_i, sb_fix_i, syndrome_i, data_i, clr_i, log_ack_i,
    output sb_cnt_o, db_cnt_o, log_valid_o, log_type_o, log_syndrome_o, log_data_o,
           log_ovf_o, alarm_o, fatal_o
  );
endinterface

// File: rtl/secded_err_monitor.sv
// SECDED error monitor: saturating CE/UE counters, one-entry error log with ack, and an OK/DEGRADED/FATAL health FSM.
// Define SECDED_MON_TS_EN to add a free-running 16-bit cycle counter and the log_ts_o capture port.
module secded_err_monitor #(
  parameter int K         = 4,
  parameter int M         = 3,
  parameter int CNT_W     = 8,
  parameter int SB_THRESH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef SECDED_MON_TS_EN
  output logic [15:0] log_ts_o,
`endif
  secded_err_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_FATAL    = 2'd2
  } health_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(SB_THRESH);

  health_t          state_q, state_d;
  logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             log_valid_q, log_valid_d;
  logic             log_type_q, log_type_d;
  logic [M:0]       log_syndrome_q, log_syndrome_d;
  logic [K-1:0]     log_data_q, log_data_d;
  logic             log_ovf_q, log_ovf_d;

  logic             is_ce, is_ue, is_err, ack_eff, capture;

`ifdef SECDED_MON_TS_EN
  logic [15:0]      ts_q, ts_d;
  logic [15:0]      log_ts_q, log_ts_d;
`endif

  // db_err wins; a single-bit error the decoder could not fix counts as uncorrectable.
  always_comb begin
    is_ue   = bus.valid_i & (bus.db_err_i | (bus.sb_err_i & ~bus.sb_fix_i));
    is_ce   = bus.valid_i & ~bus.db_err_i & bus.sb_err_i & bus.sb_fix_i;
    is_err  = is_ce | is_ue;
    ack_eff = bus.log_ack_i & log_valid_q;
    capture = is_err & (~log_valid_q | ack_eff);
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    state_d        = state_q;
    sb_cnt_d       = sb_cnt_q;
    db_cnt_d       = db_cnt_q;
    log_valid_d    = log_valid_q & ~ack_eff;
    log_type_d     = log_type_q;
    log_syndrome_d = log_syndrome_q;
    log_data_d     = log_data_q;
    log_ovf_d      = log_ovf_q;
`ifdef SECDED_MON_TS_EN
    ts_d           = ts_q + 16'd1;
    log_ts_d       = log_ts_q;
`endif

    if (bus.clr_i) begin
      state_d        = ST_OK;
      sb_cnt_d       = '0;
      db_cnt_d       = '0;
      log_valid_d    = 1'b0;
      log_type_d     = 1'b0;
      log_syndrome_d = '0;
      log_data_d     = '0;
      log_ovf_d      = 1'b0;
`ifdef SECDED_MON_TS_EN
      log_ts_d       = '0;
`endif
    end else begin
      if (is_ce && sb_cnt_q != CNT_MAX) sb_cnt_d = sb_cnt_q + 1'b1;
      if (is_ue && db_cnt_q != CNT_MAX) db_cnt_d = db_cnt_q + 1'b1;

      if (capture) begin
        log_valid_d    = 1'b1;
        log_type_d     = is_ue;
        log_syndrome_d = bus.syndrome_i;
        log_data_d     = bus.data_i;
`ifdef SECDED_MON_TS_EN
        log_ts_d       = ts_q;
`endif
      end else if (is_err) begin
        log_ovf_d = 1'b1;
      end

      // Threshold uses the post-update count so alarm rises with the counter.
      unique case (state_q)
        ST_OK: begin
          if (is_ue)                       state_d = ST_FATAL;
          else if (sb_cnt_d >= THRESH_C)   state_d = ST_DEGRADED;
        end
        ST_DEGRADED: begin
          if (is_ue) state_d = ST_FATAL;
        end
        ST_FATAL:    state_d = ST_FATAL;
        default:     state_d = ST_FATAL;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_OK;
      sb_cnt_q       <= '0;
      db_cnt_q       <= '0;
      log_valid_q    <= 1'b0;
      log_type_q     <= 1'b0;
      // NOTE: the log payload is reset too because it drives ports that must read 0 out of reset.
      log_syndrome_q <= '0;
      log_data_q     <= '0;
      log_ovf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q        <= state_d;
      sb_cnt_q       <= sb_cnt_d;
      db_cnt_q       <= db_cnt_d;
      log_valid_q    <= log_valid_d;
      log_type_q     <= log_type_d;
      log_syndrome_q <= log_syndrome_d;
      log_data_q     <= log_data_d;
      log_ovf_q      <= log_ovf_d;
    end
  end

`ifdef SECDED_MON_TS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q     <= '0;
      log_ts_q <= '0;
    end else begin
      ts_q     <= ts_d;
      log_ts_q <= log_ts_d;
    end
  end

  assign log_ts_o = log_ts_q;
`endif

  assign bus.sb_cnt_o       = sb_cnt_q;
  assign bus.db_cnt_o       = db_cnt_q;
  assign bus.log_valid_o    = log_valid_q;
  assign bus.log_type_o     = log_type_q;
  assign bus.log_syndrome_o = log_syndrome_q;
  assign bus.log_data_o     = log_data_q;
  assign bus.log_ovf_o      = log_ovf_q;
  assign bus.alarm_o        = (state_q != ST_OK);
  assign bus.fatal_o        = (state_q == ST_FATAL);

endmodule

// File: tb/tb_secded_err_monitor.sv
// Self-checking bench for secded_err_monitor: directed scenarios plus randomized traffic
// compared against a behavioural model of counters, log and health level.
module tb_secded_err_monitor;

  localparam int K         = 4;
  localparam int M         = 3;
  localparam int CNT_W     = 8;
  localparam int SB_THRESH = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
`ifdef SECDED_MON_TS_EN
  logic [15:0] log_ts_o;
`endif

  secded_err_monitor_if #(.K(K), .M(M), .CNT_W(CNT_W)) bus ();

  secded_err_monitor #(.K(K), .M(M), .CNT_W(CNT_W), .SB_THRESH(SB_THRESH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
`ifdef SECDED_MON_TS_EN
    .log_ts_o (log_ts_o),
`endif
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: health 0=OK, 1=DEGRADED, 2=FATAL.
  int m_sb, m_db, m_lv, m_type, m_syn, m_data, m_ovf, m_health;
  int m_ts, m_log_ts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sb = 0; m_db = 0; m_lv = 0; m_type = 0; m_syn = 0; m_data = 0;
    m_ovf = 0; m_health = 0; m_ts = 0; m_log_ts = 0;
  endtask

  task automatic model_update(input bit v, sb, db, fix, input int syn, dat, input bit clr, ack);
    bit ue, ce;
    int ts_now;
    ts_now = m_ts;
    m_ts   = (m_ts + 1) % 65536;
    if (clr) begin
      m_sb = 0; m_db = 0; m_lv = 0; m_type = 0; m_syn = 0; m_data = 0;
      m_ovf = 0; m_health = 0; m_log_ts = 0;
      return;
    end
    ue = v && (db || (sb && !fix));
    ce = v && !db && sb && fix;
    if (ce && m_sb < CNT_MAX) m_sb++;
    if (ue && m_db < CNT_MAX) m_db++;
    if (ack && m_lv != 0) m_lv = 0;
    if (ce || ue) begin
      if (m_lv == 0) begin
        m_lv = 1; m_type = ue ? 1 : 0; m_syn = syn; m_data = dat; m_log_ts = ts_now;
      end else begin
        m_ovf = 1;
      end
    end
    if (ue) m_health = 2;
    else if (m_health == 0 && m_sb >= SB_THRESH) m_health = 1;
  endtask

  task automatic compare_all();
    check("sb_cnt",   32'(bus.sb_cnt_o),       32'(m_sb));
    check("db_cnt",   32'(bus.db_cnt_o),       32'(m_db));
    check("log_vld",  32'(bus.log_valid_o),    32'(m_lv));
    check("log_type", 32'(bus.log_type_o),     32'(m_type));
    check("log_syn",  32'(bus.log_syndrome_o), 32'(m_syn));
    check("log_dat",  32'(bus.log_data_o),     32'(m_data));
    check("log_ovf",  32'(bus.log_ovf_o),      32'(m_ovf));
    check("alarm",    32'(bus.alarm_o),        32'(m_health != 0));
    check("fatal",    32'(bus.fatal_o),        32'(m_health == 2));
`ifdef SECDED_MON_TS_EN
    check("log_ts",   32'(log_ts_o),           32'(m_log_ts));
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input bit v, sb, db, fix, input logic [3:0] syn, dat,
                      input bit clr, ack, input bit cmp);
    bus.valid_i    = v;
    bus.sb_err_i   = sb;
    bus.db_err_i   = db;
    bus.sb_fix_i   = fix;
    bus.syndrome_i = syn;
    bus.data_i     = dat;
    bus.clr_i      = clr;
    bus.log_ack_i  = ack;
    @(posedge clk_i);
    model_update(v, sb, db, fix, int'(syn), int'(dat), clr, ack);
    #1;
    if (cmp) compare_all();
  endtask

  task automatic idle(input int n, input bit cmp);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0, 4'h0, 0, 0, cmp);
  endtask

  task automatic clear();
    step(0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 1);
  endtask

  initial begin
    bit v, sb, db, fix, clr, ack;
    logic [3:0] syn, dat;

    bus.valid_i = 0; bus.sb_err_i = 0; bus.db_err_i = 0; bus.sb_fix_i = 0;
    bus.syndrome_i = '0; bus.data_i = '0; bus.clr_i = 0; bus.log_ack_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    compare_all();

`ifdef SECDED_MON_TS_EN
    // Counter reads 10 at the eleventh edge after release; that edge samples the CE.
    idle(10, 1);
    step(1, 1, 0, 1, 4'h3, 4'h9, 0, 0, 1);
    check("ts_at_10", 32'(log_ts_o), 32'd10);
    clear();
`endif

    // Four CEs reach the threshold; only the first is logged.
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 1, 4'h5, 4'(i + 1), 0, 0, 1);
      check("alarm_thr", 32'(bus.alarm_o), 32'(i == 3));
      if (i >= 1) check("ovf_2nd", 32'(bus.log_ovf_o), 32'd1);
    end
    check("sb_four",  32'(bus.sb_cnt_o),       32'd4);
    check("type_ce",  32'(bus.log_type_o),     32'd0);
    check("syn_five", 32'(bus.log_syndrome_o), 32'h5);
    check("dat_1st",  32'(bus.log_data_o),     32'h1);

    // Two UEs via both classification paths.
    clear();
    step(1, 0, 1, 0, 4'h8, 4'hA, 0, 0, 1);
    check("fatal_ue", 32'(bus.fatal_o), 32'd1);
    step(1, 1, 0, 0, 4'h6, 4'hB, 0, 0, 1);
    check("db_two",   32'(bus.db_cnt_o),   32'd2);
    check("type_ue",  32'(bus.log_type_o), 32'd1);
    check("sb_none",  32'(bus.sb_cnt_o),   32'd0);

    // Both flags set: db wins, counted as UE only.
    clear();
    step(1, 1, 1, 1, 4'hF, 4'h2, 0, 0, 1);
    check("db_wins", 32'(bus.db_cnt_o), 32'd1);

    // Same-cycle ack and new CE: replace entry without overflow.
    clear();
    step(1, 1, 0, 1, 4'h1, 4'h3, 0, 0, 1);
    step(1, 1, 0, 1, 4'h7, 4'hC, 0, 1, 1);
    check("ack_vld", 32'(bus.log_valid_o),    32'd1);
    check("ack_syn", 32'(bus.log_syndrome_o), 32'h7);
    check("ack_ovf", 32'(bus.log_ovf_o),      32'd0);
    step(0, 0, 0, 0, 4'h0, 4'h0, 0, 1, 1);
    step(0, 0, 0, 0, 4'h0, 4'h0, 0, 1, 1);
    check("ack_empty", 32'(bus.log_valid_o), 32'd0);

    // Saturation, then clear beats a simultaneous UE.
    clear();
    for (int i = 0; i < 300; i++) step(1, 1, 0, 1, 4'h5, 4'h0, 0, 0, 1);
    check("sb_sat", 32'(bus.sb_cnt_o), 32'd255);
    step(1, 0, 1, 0, 4'h9, 4'h4, 1, 0, 1);
    check("clr_sb",    32'(bus.sb_cnt_o), 32'd0);
    check("clr_db",    32'(bus.db_cnt_o), 32'd0);
    check("clr_fatal", 32'(bus.fatal_o),  32'd0);
    check("clr_alarm", 32'(bus.alarm_o),  32'd0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      sb  = ($urandom_range(0, 1) != 0);
      db  = ($urandom_range(0, 7) == 0);
      fix = ($urandom_range(0, 7) != 0);
      syn = 4'($urandom);
      dat = 4'($urandom);
      clr = ($urandom_range(0, 49) == 0);
      ack = ($urandom_range(0, 3) == 0);
      step(v, sb, db, fix, syn, dat, clr, ack, 1);
    end

    // Asynchronous reset mid-stream with log full and FSM fatal.
    step(1, 0, 1, 0, 4'hC, 4'hD, 0, 0, 1);
    step(1, 1, 0, 1, 4'h2, 4'h2, 0, 0, 1);
    check("pre_fatal", 32'(bus.fatal_o),     32'd1);
    check("pre_vld",   32'(bus.log_valid_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    step(1, 1, 0, 1, 4'h4, 4'h6, 0, 0, 1);
    check("post_rst_sb", 32'(bus.sb_cnt_o), 32'd1);

`ifdef SECDED_MON_TS_EN
    // Timestamp is not cleared by clr and wraps at 16 bits.
    clear();
    idle(65536, 0);
    step(1, 1, 0, 1, 4'hE, 4'h1, 0, 0, 1);
    clear();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
